// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encodings and the reset PC default.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_HOLD  = 2'b01,
    ST_DRAIN = 2'b10
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Priority: flush > load > freeze (hold) > bubble.
module if_id_reg #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               flush,
  input  logic               freeze,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               valid_out
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      pc_d    = pc_in;
      instr_d = instr_in;
      valid_d = 1'b1;
    end else if (!freeze) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out    = pc_q;
  assign instr_out = instr_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC generation, req/ready fetch FSM with freeze buffering and branch redirect, feeding IF/ID.
//   state    | meaning
//   ST_FETCH | request for pc outstanding on imem
//   ST_HOLD  | instruction for pc buffered in hold_buf, ID frozen, no request
//   ST_DRAIN | stale request to drain_addr outstanding, pc already holds the branch target
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter int               INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               valid_out
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] hold_buf_q, hold_buf_d;
  logic [ADDR_W-1:0]  drain_addr_q, drain_addr_d;

  logic               ifid_load;
  logic               ifid_flush;
  logic [INSTR_W-1:0] ifid_instr;
  logic [ADDR_W-1:0]  pc_plus4;

  assign pc_plus4  = pc_q + ADDR_W'(4);
  assign imem_req  = (state_q != ST_HOLD);
  assign imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_buf_d   = hold_buf_q;
    drain_addr_d = drain_addr_q;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_instr   = imem_rdata;
    case (state_q)
      ST_FETCH: begin
        if (branch_taken) begin
          ifid_flush = 1'b1;
          pc_d       = branch_addr;
          // Without ready the old request is still owed a completion; wait it out in DRAIN.
          if (!imem_ready) begin
            drain_addr_d = pc_q;
            state_d      = ST_DRAIN;
          end
        end else if (imem_ready) begin
          if (!freeze) begin
            ifid_load = 1'b1;
            pc_d      = pc_plus4;
          end else begin
            hold_buf_d = imem_rdata;
            state_d    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (branch_taken) begin
          ifid_flush = 1'b1;
          pc_d       = branch_addr;
          state_d    = ST_FETCH;
        end else if (!freeze) begin
          ifid_load  = 1'b1;
          ifid_instr = hold_buf_q;
          pc_d       = pc_plus4;
          state_d    = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (branch_taken) begin
          ifid_flush = 1'b1;
          pc_d       = branch_addr;
        end
        if (imem_ready) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      hold_buf_q   <= '0;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_buf_q   <= hold_buf_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (ifid_load),
    .flush     (ifid_flush),
    .freeze    (freeze),
    .pc_in     (pc_plus4),
    .instr_in  (ifid_instr),
    .pc_out    (pc_out),
    .instr_out (instr_out),
    .valid_out (valid_out)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: zero-wait stream, freeze buffering, branch redirects, PC wrap, async reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;

  logic        zw;
  logic        ready_drv;
  logic [31:0] rdata_drv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Zero-wait memory returns E000_0000 | addr in the request cycle.
  assign imem_ready = zw ? imem_req : ready_drv;
  assign imem_rdata = zw ? (32'hE000_0000 | imem_addr) : rdata_drv;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .pc_out       (pc_out),
    .instr_out    (instr_out),
    .valid_out    (valid_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] d, input logic f, input logic b,
                       input logic [31:0] ba);
    ready_drv = r; rdata_drv = d; freeze = f; branch_taken = b; branch_addr = ba;
  endtask

  task automatic do_reset();
    rst = 1'b1; zw = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(); step();
    rst = 1'b0;
  endtask

  task automatic run_zw(input int n);
    zw = 1'b1;
    repeat (n) step();
    zw = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; zw = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    chk("rst_req", {31'b0, imem_req}, 32'h1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_valid", {31'b0, valid_out}, 32'h0);
    rst = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    zw = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("stream_valid", {31'b0, valid_out}, 32'h1);
      chk("stream_pc_out", pc_out, 32'(4 * k));
      chk("stream_instr", instr_out, 32'hE000_0000 | 32'(4 * (k - 1)));
    end
    zw = 1'b0;
  endtask

  task automatic test_freeze_ready();
    do_reset();
    run_zw(4);
    drive(1'b1, 32'hE3A0_1005, 1'b1, 1'b0, 32'h0);
    chk("frz_addr", imem_addr, 32'h10);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      chk("frz_req_low", {31'b0, imem_req}, 32'h0);
      chk("frz_pc_out_held", pc_out, 32'h10);
      chk("frz_instr_held", instr_out, 32'hE000_000C);
      chk("frz_valid_held", {31'b0, valid_out}, 32'h1);
      if (c < 2) step();
    end
    freeze = 1'b0;
    step();
    chk("frz_release_instr", instr_out, 32'hE3A0_1005);
    chk("frz_release_pc_out", pc_out, 32'h14);
    chk("frz_release_valid", {31'b0, valid_out}, 32'h1);
    chk("frz_next_req", {31'b0, imem_req}, 32'h1);
    chk("frz_next_addr", imem_addr, 32'h14);
  endtask

  task automatic test_branch_mid_fetch();
    do_reset();
    run_zw(16);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("bmf_req_addr", imem_addr, 32'h40);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("bmf_addr_stable1", imem_addr, 32'h40);
    chk("bmf_valid1", {31'b0, valid_out}, 32'h0);
    step();
    chk("bmf_addr_stable2", imem_addr, 32'h40);
    chk("bmf_req_held", {31'b0, imem_req}, 32'h1);
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    step();
    chk("bmf_valid_drop", {31'b0, valid_out}, 32'h0);
    chk("bmf_new_addr", imem_addr, 32'h200);
    drive(1'b1, 32'hE000_0200, 1'b0, 1'b0, 32'h0);
    step();
    chk("bmf_tgt_pc_out", pc_out, 32'h204);
    chk("bmf_tgt_instr", instr_out, 32'hE000_0200);
    chk("bmf_tgt_valid", {31'b0, valid_out}, 32'h1);
  endtask

  task automatic test_branch_hold();
    do_reset();
    run_zw(2);
    drive(1'b1, 32'h1111_1111, 1'b1, 1'b0, 32'h0);
    step();
    chk("bh_hold_valid", {31'b0, valid_out}, 32'h1);
    chk("bh_hold_req", {31'b0, imem_req}, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h300);
    step();
    chk("bh_flush_valid", {31'b0, valid_out}, 32'h0);
    chk("bh_req", {31'b0, imem_req}, 32'h1);
    chk("bh_addr", imem_addr, 32'h300);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    chk("bh_bubble_valid", {31'b0, valid_out}, 32'h0);
    drive(1'b1, 32'hABCD_0000, 1'b0, 1'b0, 32'h0);
    step();
    chk("bh_tgt_pc_out", pc_out, 32'h304);
    chk("bh_tgt_instr", instr_out, 32'hABCD_0000);
    chk("bh_tgt_valid", {31'b0, valid_out}, 32'h1);
  endtask

  task automatic test_branch_ready_freeze();
    do_reset();
    run_zw(2);
    drive(1'b1, 32'h2222_2222, 1'b1, 1'b1, 32'h500);
    step();
    chk("brf_valid", {31'b0, valid_out}, 32'h0);
    chk("brf_req", {31'b0, imem_req}, 32'h1);
    chk("brf_addr", imem_addr, 32'h500);
    drive(1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0);
    step();
    chk("brf_pc_out", pc_out, 32'h504);
    chk("brf_instr", instr_out, 32'h3333_3333);
    chk("brf_valid2", {31'b0, valid_out}, 32'h1);
  endtask

  task automatic test_wrap_reset();
    do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    drive(1'b1, 32'h4444_4444, 1'b0, 1'b0, 32'h0);
    step();
    chk("wrap_pc_out", pc_out, 32'h0);
    chk("wrap_instr", instr_out, 32'h4444_4444);
    chk("wrap_valid", {31'b0, valid_out}, 32'h1);
    chk("wrap_pc", imem_addr, 32'h0);
    drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h80);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h700);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("drain_addr", imem_addr, 32'h80);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_req", {31'b0, imem_req}, 32'h1);
    chk("arst_pc_out", pc_out, 32'h0);
    chk("arst_instr", instr_out, 32'h0);
    chk("arst_valid", {31'b0, valid_out}, 32'h0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_freeze_ready();
    test_branch_mid_fetch();
    test_branch_hold();
    test_branch_ready_freeze();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
